// File: rtl/four_12_12_st2_bias_ctrl_if.sv
// Signal bundle for the stage-2 bias controller: host writes, sweep control,
// the returned bias stream and the bias memory port.
interface four_12_12_st2_bias_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
);
   // Host write request
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   // Sweep control
   logic              sweep_start;
   logic              sweep_busy;
   logic              sweep_done;
   // Bias output stream
   logic              bias_valid;
   logic              bias_ready;
   logic [DATA_W-1:0] bias_data;
   logic [ADDR_W-1:0] bias_index;
   logic              bias_last;
   // Bias memory port (synchronous read, data one cycle after mem_rd_en)
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr_en;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data;

   // Handshakes: a write (wr_valid/wr_ready) or a beat (bias_valid/bias_ready)
   // transfers in exactly the cycles where both are 1; the sender never makes
   // valid depend on ready, and holds the payload stable while valid=1 and
   // ready=0.

   // Controller side
   modport slave (
      input  wr_valid, wr_addr, wr_data, sweep_start, bias_ready, mem_rd_data,
      output wr_ready, sweep_busy, sweep_done, bias_valid, bias_data,
             bias_index, bias_last, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data
   );

   // Host / pipeline / memory side
   modport master (
      output wr_valid, wr_addr, wr_data, sweep_start, bias_ready, mem_rd_data,
      input  wr_ready, sweep_busy, sweep_done, bias_valid, bias_data,
             bias_index, bias_last, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data
   );
endinterface

// File: rtl/four_12_12_st2_bias_ctrl.sv
// Stage-2 bias memory controller: arbitrates host writes against full read
// sweeps and streams the swept biases in index order through a 2-entry FIFO.
module four_12_12_st2_bias_ctrl #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 4,
   parameter int ADDR_W       = 2,
   parameter int MAX_WR_BURST = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   four_12_12_st2_bias_ctrl_if.slave bus_if,
   output logic [1:0]                state_o
);
   localparam int BURST_W = $clog2(MAX_WR_BURST + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]         state_q, state_d;
   logic               pending_q, pending_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic               in_flight_q;
   logic [ADDR_W-1:0]  in_flight_idx_q;
   logic               done_q, done_d;

   // Output FIFO: slot 0 is always the head
   logic [1:0]         fifo_cnt_q, fifo_cnt_d;
   logic [DATA_W-1:0]  s0_data_q, s0_data_d, s1_data_q, s1_data_d;
   logic [ADDR_W-1:0]  s0_idx_q, s0_idx_d, s1_idx_q, s1_idx_d;

   logic               is_idle, burst_full, wr_ready, wr_acc, sweep_go;
   logic               pop, push, rd_issue, last_pop;
   logic [2:0]         occ;

   assign is_idle    = (state_q == ST_IDLE);
   assign burst_full = pending_q && (burst_cnt_q == BURST_W'(MAX_WR_BURST));
   // Held low while reset is asserted so every output reads 0 in reset
   assign wr_ready   = reset && is_idle && !burst_full;
   assign wr_acc     = bus_if.wr_valid && wr_ready;
   // A sweep starts from IDLE only in a cycle with no accepted write
   assign sweep_go   = is_idle && (pending_q || bus_if.sweep_start) && !wr_acc;

   assign pop      = (fifo_cnt_q != 2'd0) && bus_if.bias_ready;
   assign push     = in_flight_q;
   assign last_pop = pop && (s0_idx_q == ADDR_W'(DEPTH - 1));

   // Credit: FIFO entries plus outstanding read, less this cycle's pop, must
   // stay below the 2-entry FIFO capacity for a new read to be issued.
   assign occ      = {1'b0, fifo_cnt_q} + {2'b00, in_flight_q};
   assign rd_issue = (state_q == ST_SWEEP) && (occ < (3'd2 + {2'b00, pop}));

   // Control next-state: FSM, pending sweep, write burst count, read pointer
   always_comb begin
      state_d     = state_q;
      pending_d   = (pending_q || bus_if.sweep_start) && !sweep_go;
      burst_cnt_d = burst_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      done_d      = (state_q == ST_DRAIN) && last_pop;

      case (state_q)
         ST_IDLE:  if (sweep_go) state_d = ST_SWEEP;
         ST_SWEEP: if (rd_issue && (rd_ptr_q == ADDR_W'(DEPTH - 1))) state_d = ST_DRAIN;
         ST_DRAIN: if (last_pop) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (sweep_go) begin
         burst_cnt_d = '0;
         rd_ptr_d    = '0;
      end else begin
         if (wr_acc && pending_q && !burst_full) burst_cnt_d = burst_cnt_q + BURST_W'(1);
         if (rd_issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
   end

   // FIFO next-state: capture returning read data, shift on pop
   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      s0_data_d  = s0_data_q;
      s0_idx_d   = s0_idx_q;
      s1_data_d  = s1_data_q;
      s1_idx_d   = s1_idx_q;
      case ({push, pop})
         2'b10: begin
            if (fifo_cnt_q == 2'd0) begin
               s0_data_d = bus_if.mem_rd_data;
               s0_idx_d  = in_flight_idx_q;
            end else begin
               s1_data_d = bus_if.mem_rd_data;
               s1_idx_d  = in_flight_idx_q;
            end
            fifo_cnt_d = fifo_cnt_q + 2'd1;
         end
         2'b01: begin
            s0_data_d  = s1_data_q;
            s0_idx_d   = s1_idx_q;
            fifo_cnt_d = fifo_cnt_q - 2'd1;
         end
         2'b11: begin
            if (fifo_cnt_q == 2'd1) begin
               s0_data_d = bus_if.mem_rd_data;
               s0_idx_d  = in_flight_idx_q;
            end else begin
               s0_data_d = s1_data_q;
               s0_idx_d  = s1_idx_q;
               s1_data_d = bus_if.mem_rd_data;
               s1_idx_d  = in_flight_idx_q;
            end
         end
         default: ;
      endcase
   end

   // Control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         pending_q       <= 1'b0;
         burst_cnt_q     <= '0;
         rd_ptr_q        <= '0;
         in_flight_q     <= 1'b0;
         in_flight_idx_q <= '0;
         done_q          <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         burst_cnt_q <= burst_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         in_flight_q <= rd_issue;
         if (rd_issue) in_flight_idx_q <= rd_ptr_q;
         done_q      <= done_d;
      end
   end

   // FIFO registers; reset discards any buffered beats
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_cnt_q <= 2'd0;
         s0_data_q  <= '0;
         s0_idx_q   <= '0;
         s1_data_q  <= '0;
         s1_idx_q   <= '0;
      end else begin
         fifo_cnt_q <= fifo_cnt_d;
         s0_data_q  <= s0_data_d;
         s0_idx_q   <= s0_idx_d;
         s1_data_q  <= s1_data_d;
         s1_idx_q   <= s1_idx_d;
      end
   end

   assign bus_if.wr_ready    = wr_ready;
   assign bus_if.sweep_busy  = pending_q || !is_idle;
   assign bus_if.sweep_done  = done_q;
   assign bus_if.bias_valid  = (fifo_cnt_q != 2'd0);
   assign bus_if.bias_data   = (fifo_cnt_q != 2'd0) ? s0_data_q : '0;
   assign bus_if.bias_index  = (fifo_cnt_q != 2'd0) ? s0_idx_q : '0;
   assign bus_if.bias_last   = (fifo_cnt_q != 2'd0) && (s0_idx_q == ADDR_W'(DEPTH - 1));
   assign bus_if.mem_wr_en   = wr_acc;
   assign bus_if.mem_rd_en   = rd_issue;
   assign bus_if.mem_wr_data = wr_acc ? bus_if.wr_data : '0;
   assign bus_if.mem_addr    = wr_acc ? bus_if.wr_addr : (rd_issue ? rd_ptr_q : '0);
   assign state_o            = state_q;
endmodule

// File: doc/four_12_12_st2_bias_ctrl.md
Name: four_12_12_st2_bias_ctrl

Overview:
Controller and arbiter for the stage-2 bias memory, a 4-entry x 32-bit memory with synchronous read. It shares the memory between a host bias loader (write requester) and the stage-2 compute pipeline, which requests full read sweeps of all entries. It drives the memory's flat address, enable and data lines. It returns swept biases in index order through a valid/ready stream with full throughput under back-pressure.

Parameters:
DATA_W, 32, bias word width
DEPTH, 4, number of bias entries
ADDR_W, 2, address width (log2 DEPTH)
MAX_WR_BURST, 4, maximum consecutive write grants while a sweep is pending

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  host write request
wr_addr  in  ADDR_W  host write address
wr_data  in  DATA_W  host write data
wr_ready  out  1  host write accepted this cycle (when wr_valid=1)
sweep_start  in  1  one-cycle request for a full bias sweep
sweep_busy  out  1  sweep pending or in progress
sweep_done  out  1  one-cycle pulse when the last beat is accepted
bias_valid  out  1  output beat valid
bias_ready  in  1  downstream accepts beat
bias_data  out  DATA_W  bias word
bias_index  out  ADDR_W  entry index of the beat
bias_last  out  1  beat is entry DEPTH-1
mem_addr  out  ADDR_W  memory address
mem_wr_en  out  1  memory write enable
mem_rd_en  out  1  memory read enable
mem_wr_data  out  DATA_W  memory write data
mem_rd_data  in  DATA_W  memory read data, valid one cycle after mem_rd_en

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pending=0, burst count=0, FIFO empty, in-flight=0. All outputs are 0, including wr_ready.
- States:
  - IDLE.
  - SWEEP: issuing reads.
  - DRAIN: all reads issued; waiting for the FIFO to empty.
- Write arbitration (IDLE only):
  - wr_ready = (state==IDLE) && !(pending && burst_cnt==MAX_WR_BURST).
  - An accepted write drives mem_wr_en=1, mem_addr=wr_addr and mem_wr_data=wr_data in the same cycle.
  - burst_cnt increments per accepted write while pending=1; it clears on sweep entry.
  - wr_ready=0 throughout SWEEP/DRAIN, so a sweep always returns a coherent bias set.
- Sweep request:
  - sweep_start sets pending in any state; a start while busy is queued (one deep).
  - IDLE with pending=1 and no write accepted this cycle: move to SWEEP at the next edge, clear pending and set rd_ptr=0.
  - sweep_busy = pending || state!=IDLE.
- Write priority: a write and a pending sweep in the same IDLE cycle -> the write wins, up to MAX_WR_BURST consecutive writes. After that the sweep is forced (wr_ready=0).
- SWEEP read issue:
  - Issue mem_rd_en=1, mem_addr=rd_ptr when fifo_count + in_flight - pop < 2, where pop = bias_valid && bias_ready. This credit rule guarantees the 2-entry output FIFO never overflows.
  - rd_ptr increments per issue. After issuing DEPTH-1, go to DRAIN.
- Read return: mem_rd_data is captured into the FIFO with its index one cycle after issue (in_flight decrements).
- Output stream:
  - FIFO head drives bias_data, bias_index and bias_last (bias_last = index==DEPTH-1).
  - bias_valid = FIFO non-empty; beat data is held stable while bias_valid=1 and bias_ready=0.
- DRAIN: when the beat with bias_last is accepted, pulse sweep_done for 1 cycle and go to IDLE. If pending=1, the next sweep starts through the IDLE arbitration.
- Latency: sweep_start sampled at cycle N in IDLE with no writes -> SWEEP at N+1 (read idx0) -> capture at N+2 -> bias_valid=1 at N+3.
  - With bias_ready held at 1, beats arrive on consecutive cycles N+3..N+6.
  - sweep_done=1 in cycle N+7.
- Mutual exclusion: mem_wr_en and mem_rd_en are never both 1 in one cycle.
- Reset mid-sweep: everything returns to the reset state, FIFO contents are discarded, and no sweep_done is generated.

Test Plan:
- Write 0x11111111, 0x22222222, 0x33333333, 0x44444444 to addrs 0..3, then pulse sweep_start with bias_ready=1 -> 4 beats on consecutive cycles starting 3 cycles after start. Data appears in index order 0..3, bias_last only on index 3, then one sweep_done pulse.
- Same sweep with bias_ready toggling 1,0,0,1,0,1... -> no beat lost or duplicated, data held stable while stalled, and mem_rd_en is never issued with 2 entries outstanding.
- wr_valid held high continuously and sweep_start pulsed once -> exactly 4 writes accepted, then wr_ready=0 and the sweep runs. Writes are refused until sweep_done, and the sweep returns the post-burst memory values.
- sweep_start pulsed again during an active sweep -> the second sweep runs back-to-back after sweep_done, with sweep_busy held at 1 throughout.
- Assert reset low after beat 1 of a sweep -> all outputs are 0 immediately. After release the FIFO is empty, no sweep_done is seen, and wr_ready=1.
- A write and sweep_start in the same IDLE cycle -> the write is performed first, and the sweep returns the newly written value at that address.
